// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//   Front-end stage for the CPU control block. Fetches 16-bit instruction words
//   over a req/ack handshake and latches each word into the instruction
//   register (IR). The opcode is decoded into the one-hot A_in vector, and the
//   register-select and immediate fields are exposed. The PC advances by one or
//   loads a branch target, based on the control block's branch-taken bit.
//
// Ports
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   imem_req       : fetch request; held high until acknowledged
//   imem_addr      : fetch address (always equal to pc)
//   imem_ack       : memory acknowledge; imem_rdata is valid in the same cycle
//   imem_rdata     : instruction word
//   branch_taken   : control block c[1]; sampled only in an unstalled EXEC cycle
//   branch_target  : next PC when branch_taken is 1
//   exec_stall     : holds the current instruction in EXEC
//   a_out          : one-hot decoded opcode (zero unless dec_valid)
//   rx_ry          : {Rx, Ry} = IR[10:7]
//   imm            : IR[6:0], unsigned
//   dec_valid      : a_out/rx_ry/imm are valid and may commit
//   pc             : current instruction address
//   halted         : sticky; set by an illegal opcode, cleared only by reset
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter int unsigned    AW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          exec_stall,
  output logic [22:0]   a_out,
  output logic [3:0]    rx_ry,
  output logic [6:0]    imm,
  output logic          dec_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_LEGAL_OP = 5'd22;

  state_t        state;
  logic [AW-1:0] pc_q;
  logic [15:0]   ir;
  logic          req_q;
  logic          valid_q;
  logic          halt_q;
  logic [4:0]    opcode;
  logic          fetch_legal;

  assign opcode      = ir[15:11];
  assign fetch_legal = (imem_rdata[15:11] <= LAST_LEGAL_OP);

  // State, PC, IR and the handshake/status flags all live in one block. The
  // flags are registered alongside the state transition so that they always
  // match the state they describe, and no output depends combinationally on
  // imem_rdata or branch_taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      ir      <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end

        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            req_q <= 1'b0;
            if (fetch_legal) begin
              state   <= S_EXEC;
              valid_q <= 1'b1;
            end else begin
              state  <= S_HALT;
              halt_q <= 1'b1;
            end
          end
        end

        S_EXEC: begin
          // A stall freezes everything, so a branch seen during the stall is
          // re-evaluated in the first unstalled cycle.
          if (!exec_stall) begin
            pc_q    <= branch_taken ? branch_target : pc_q + AW'(1);
            state   <= S_FETCH;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end

        S_HALT: begin
          state   <= S_HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          halt_q  <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-hot opcode decode, gated by dec_valid so a_out is zero outside EXEC.
  always_comb begin
    a_out = '0;
    for (int unsigned i = 0; i < 23; i++) begin
      a_out[i] = valid_q && (opcode == 5'(i));
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dec_valid = valid_q;
  assign halted    = halt_q;
  assign rx_ry     = ir[10:7];
  assign imm       = ir[6:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        exec_stall;
  logic [22:0] a_out;
  logic [3:0]  rx_ry;
  logic [6:0]  imm;
  logic        dec_valid;
  logic [7:0]  pc;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: address of the instruction currently being fetched.
  logic [7:0] mpc;

  instr_fetch_decode #(
    .AW      (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .exec_stall   (exec_stall),
    .a_out        (a_out),
    .rx_ry        (rx_ry),
    .imm          (imm),
    .dec_valid    (dec_valid),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_legal();
    logic [4:0]  op;
    logic [10:0] rest;
    op   = 5'($urandom_range(0, 22));
    rest = 11'($urandom);
    return {op, rest};
  endfunction

  // One full instruction: entered and left in a FETCH cycle (#1 after an edge).
  // Expected values come from the instruction-format rules, not the DUT.
  task automatic run_instr(input logic [15:0] word, input int waits, input int stalls,
                           input logic br, input logic [7:0] tgt);
    logic [22:0] exp_a;
    exp_a = 23'd1 << word[15:11];
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(mpc));
      chk("wait_nodv", 32'(dec_valid), 32'd0);
      imem_ack      = 1'b0;
      imem_rdata    = 16'($urandom);
      branch_taken  = 1'($urandom);
      branch_target = 8'($urandom);
      step();
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(mpc));
    imem_ack     = 1'b1;
    imem_rdata   = word;
    branch_taken = 1'($urandom);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    chk("exec_dv", 32'(dec_valid), 32'd1);
    chk("exec_a_out", 32'(a_out), 32'(exp_a));
    chk("exec_rx_ry", 32'(rx_ry), 32'(word[10:7]));
    chk("exec_imm", 32'(imm), 32'(word[6:0]));
    chk("exec_noreq", 32'(imem_req), 32'd0);
    chk("exec_pc", 32'(pc), 32'(mpc));
    for (int s = 0; s < stalls; s++) begin
      exec_stall    = 1'b1;
      branch_taken  = 1'($urandom);
      branch_target = 8'($urandom);
      imem_ack      = 1'($urandom);
      step();
      chk("stall_dv", 32'(dec_valid), 32'd1);
      chk("stall_a_out", 32'(a_out), 32'(exp_a));
      chk("stall_pc", 32'(pc), 32'(mpc));
      chk("stall_noreq", 32'(imem_req), 32'd0);
    end
    exec_stall    = 1'b0;
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = 1'($urandom);
    step();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    mpc = br ? tgt : mpc + 8'd1;
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", 32'(imem_addr), 32'(mpc));
    chk("next_pc", 32'(pc), 32'(mpc));
    chk("next_nodv", 32'(dec_valid), 32'd0);
    chk("next_a_zero", 32'(a_out), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    exec_stall    = 1'b0;
    mpc           = 8'h00;

    // Reset state, with an ack present during reset that must be ignored.
    step();
    imem_ack   = 1'b1;
    imem_rdata = 16'h0900;
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_dv", 32'(dec_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_rx_ry", 32'(rx_ry), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);
    imem_ack = 1'b0;

    // Release: IDLE for one cycle, then the request appears.
    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req), 32'd0);
    step();

    // Zero-wait fetch of 16'h0900: opcode 1, Rx=0, Ry=2.
    run_instr(16'h0900, 0, 0, 1'b0, 8'h00);

    // Walk pc 1 -> 5, then branch to 8'h40.
    for (int k = 0; k < 4; k++) run_instr(rand_legal(), 0, 0, 1'b0, 8'h00);
    run_instr(rand_legal(), 0, 0, 1'b1, 8'h40);
    // Three wait states, branch back to 5, then the not-taken case gives 6.
    run_instr(rand_legal(), 3, 0, 1'b1, 8'h05);
    run_instr(rand_legal(), 0, 0, 1'b0, 8'h77);
    // Four-cycle stall with branch_taken toggling; release not taken / taken.
    run_instr(rand_legal(), 0, 4, 1'b0, 8'h12);
    run_instr(rand_legal(), 1, 4, 1'b1, 8'hFF);
    // pc 8'hFF plus one wraps to 8'h00.
    run_instr(rand_legal(), 2, 0, 1'b0, 8'h00);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      run_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 8'($urandom));
    end

    // Illegal opcode 23: halts with pc frozen at the illegal instruction.
    chk("ill_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'hB800;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_nodv", 32'(dec_valid), 32'd0);
      chk("halt_noreq", 32'(imem_req), 32'd0);
      chk("halt_a_zero", 32'(a_out), 32'd0);
      chk("halt_pc", 32'(pc), 32'(mpc));
      imem_ack      = 1'($urandom);
      imem_rdata    = rand_legal();
      branch_taken  = 1'($urandom);
      branch_target = 8'($urandom);
      exec_stall    = 1'($urandom);
      step();
    end
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    exec_stall   = 1'b0;

    // Only reset leaves HALT.
    rst_n = 1'b0;
    #1;
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_pc", 32'(pc), 32'd0);
    chk("unhalt_req", 32'(imem_req), 32'd0);
    #1;
    rst_n = 1'b1;
    mpc   = 8'h00;
    step();
    run_instr(16'h0900, 0, 0, 1'b0, 8'h00);

    // Mid-fetch reset with ack held high: request drops inside the reset cycle.
    imem_ack   = 1'b1;
    imem_rdata = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req", 32'(imem_req), 32'd0);
    chk("mid_pc", 32'(pc), 32'd0);
    chk("mid_rx_ry", 32'(rx_ry), 32'd0);
    chk("mid_imm", 32'(imm), 32'd0);
    step();
    chk("mid_hold_req", 32'(imem_req), 32'd0);
    chk("mid_hold_rx_ry", 32'(rx_ry), 32'd0);
    chk("mid_hold_imm", 32'(imm), 32'd0);
    chk("mid_hold_dv", 32'(dec_valid), 32'd0);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
